// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer state
// encoding and an address-width helper.
package reg_file_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clear_state_t;

    // Smallest r with 2**r >= value; lets users derive ADDR_BITS from a depth.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Soft-clear sequencer: walks clear_ptr over every entry, one per cycle,
// and stalls writers while doing so. All outputs are registered.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_req,
    output logic                 clear_en,
    output logic [ADDR_BITS-1:0] clear_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_ready
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

    clear_state_t         state;
    logic [ADDR_BITS-1:0] clear_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            clear_ptr <= '0;
            clear_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_ready  <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_ptr == LAST_ADDR) begin
                        state     <= ST_DONE;
                        clear_ptr <= '0;
                        clear_en  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        wr_ready  <= 1'b1;
                    end else begin
                        clear_ptr <= clear_ptr + 1'b1;
                    end
                end
                // IDLE and DONE both take a new request; any illegal code lands here too.
                default: begin
                    done <= 1'b0;
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        clear_ptr <= '0;
                        clear_en  <= 1'b1;
                        busy      <= 1'b1;
                        wr_ready  <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign clear_addr = clear_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_READ combinational reads, two prioritised
// write ports, optional write-through bypass, optional zero register, soft clear.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr0_valid,
    input  logic [ADDR_BITS-1:0]            wr0_addr,
    input  logic [DATA_WIDTH-1:0]           wr0_data,
    input  logic                            wr1_valid,
    input  logic [ADDR_BITS-1:0]            wr1_addr,
    input  logic [DATA_WIDTH-1:0]           wr1_data,
    output logic                            wr_ready,
    input  logic [NUM_READ*ADDR_BITS-1:0]   rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    input  logic                            clear_req,
    output logic                            clear_busy,
    output logic                            clear_done
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clear_en;
    logic [ADDR_BITS-1:0]  clear_addr;
    logic                  wr0_acc;
    logic                  wr1_acc;

    reg_file_clear_seq #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_en   (clear_en),
        .clear_addr (clear_addr),
        .busy       (clear_busy),
        .done       (clear_done),
        .wr_ready   (wr_ready)
    );

    // Writes to the zero register are dropped at acceptance so they cannot reach the bypass either.
    assign wr0_acc = wr0_valid && wr_ready && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign wr1_acc = wr1_valid && wr_ready && !((ZERO_REG != 0) && (wr1_addr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_en) begin
            mem[clear_addr] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr1_acc && (wr1_addr == ADDR_BITS'(i))) begin
                    mem[i] <= wr1_data;
                end else if (wr0_acc && (wr0_addr == ADDR_BITS'(i))) begin
                    mem[i] <= wr0_data;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_BITS-1:0]  addr;
        logic [DATA_WIDTH-1:0] val;

        assign addr = rd_addr[k*ADDR_BITS +: ADDR_BITS];

        always_comb begin
            val = mem[addr];
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val = '0;
            end else if ((BYPASS != 0) && wr1_acc && (wr1_addr == addr)) begin
                val = wr1_data;
            end else if ((BYPASS != 0) && wr0_acc && (wr0_addr == addr)) begin
                val = wr0_data;
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = val;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the single-cycle datapath.
- Provides NUM_READ combinational read ports and two prioritised write ports with valid/ready handshake.
- Optional write-through bypass and an optional hard-wired zero register.
- A sequenced soft-clear engine zeroes the array one entry per cycle without asserting reset.

Parameters:
- DATA_WIDTH, 8, width of each register.
- ADDR_BITS, 2, address width; DEPTH = 2**ADDR_BITS entries, exactly.
- NUM_READ, 2, number of read ports, 1..8.
- BYPASS, 1, 1 = a same-cycle accepted write is forwarded to matching read ports.
- ZERO_REG, 0, 1 = entry 0 reads 0 and ignores writes.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr0_valid  input  1  write request, port 0.
- wr0_addr  input  ADDR_BITS  write address, port 0.
- wr0_data  input  DATA_WIDTH  write data, port 0.
- wr1_valid  input  1  write request, port 1 (higher priority).
- wr1_addr  input  ADDR_BITS  write address, port 1.
- wr1_data  input  DATA_WIDTH  write data, port 1.
- wr_ready  output  1  writes are accepted this cycle (shared by both ports).
- rd_addr  input  NUM_READ*ADDR_BITS  packed read addresses; port k uses bits [k*ADDR_BITS +: ADDR_BITS].
- rd_data  output  NUM_READ*DATA_WIDTH  packed read data, same packing.
- clear_req  input  1  start a soft clear.
- clear_busy  output  1  soft clear in progress.
- clear_done  output  1  one-cycle pulse when the soft clear completes.

Behaviour:
- Reset (asynchronous): all entries 0; state IDLE; clear_ptr 0; clear_busy 0; clear_done 0; wr_ready 1 on the first cycle after reset.

Write path:
- A write occurs on the clk edge when wrN_valid && wr_ready.
- Both ports may write in the same cycle to different addresses.
- Same address on both ports: port 1 data is stored; port 0 is dropped silently.
- ZERO_REG=1: writes to address 0 are ignored, and every read of address 0 returns 0, including through bypass.
- Write data is stored unmodified; no arithmetic.

Read path:
- Combinational from the array; no clock latency.
- BYPASS=1: if an accepted write targets rd_addr[k], rd_data[k] = that write's data (port 1 beats port 0), else array contents.
- BYPASS=0: the old value is visible until the edge; the new value appears the cycle after.
- Any number of read ports may use the same address.

Clear FSM, states IDLE, CLEAR, DONE:
- IDLE:
  - wr_ready=1, clear_busy=0.
  - clear_req=1 goes to CLEAR next cycle with clear_ptr=0.
  - A write in the same cycle as clear_req is still accepted (and is then cleared).
- CLEAR:
  - wr_ready=0, clear_busy=1.
  - Each cycle zeroes entry[clear_ptr] and increments clear_ptr.
  - After zeroing entry DEPTH-1, go to DONE; CLEAR lasts exactly DEPTH cycles.
  - Writes are stalled (not accepted, no data loss at this interface; the master holds valid).
  - clear_req is ignored.
  - Reads return current array contents: partially cleared values are legal.
- DONE:
  - clear_done=1 for one cycle, clear_busy=0, wr_ready=1.
  - Go to IDLE next cycle.
  - clear_req in DONE is accepted the same as in IDLE.
- clear_ptr is ADDR_BITS wide; the terminal condition is clear_ptr == DEPTH-1, so there is no wrap ambiguity.
- Reset asserted mid-CLEAR: immediate return to the reset state; all entries 0.

Decomposition:
- Shared package reg_file_pkg:
  - state encoding localparams ST_IDLE, ST_CLEAR, ST_DONE (2 bits);
  - function clog2 for users deriving ADDR_BITS.
- One natural sub-module, reg_file_clear_seq: the FSM plus clear_ptr, outputting clear_en, clear_addr, busy, done, wr_ready.
- The array, write priority and bypass muxes stay in the top module (generate loop over NUM_READ).

Test Plan:
- Reset then read: assert reset mid-run with non-zero contents -> all rd_data=0, wr_ready=1, clear_busy=0 immediately.
- Dual write, distinct addresses: wr0 addr1=0x11, wr1 addr2=0x22 -> next cycle rd addr1=0x11, addr2=0x22.
- Write conflict: both ports write addr3, wr0=0xAA, wr1=0x55 -> entry3=0x55.
- Bypass, BYPASS=1: write addr1=0x7E while rd_addr[0]=1 -> rd_data[0]=0x7E the same cycle. BYPASS=0 -> old value that cycle, 0x7E the next.
- Soft clear, DEPTH=4, all entries 0xFF: pulse clear_req ->
  - clear_busy high for exactly 4 cycles, with entry k zeroed in clear cycle k;
  - wr1_valid held through the clear is accepted only in the DONE cycle;
  - clear_done is a single pulse;
  - clear_req during CLEAR has no effect.
- ZERO_REG=1: write addr0=0x33 -> rd addr0=0 with bypass on and off; reset during CLEAR cycle 2 -> FSM IDLE, all entries 0.
